// File: rtl/mux_nway_reg.sv
// mux_nway_reg: registered N:1 datapath mux with per-input valid/ready
// handshakes. Selection is either explicit (sel) or round-robin among
// valid inputs. The output has one register stage by default.
//
// Optional build macro MUX_NWAY_SKID_EN: the output stage becomes a
// 2-entry skid buffer, so in_ready depends only on registered occupancy.
//
// Handshake rule (every port pair): a word moves when valid and ready are
// both 1 at a rising clock edge; valid never waits on ready, and a holder
// of valid keeps its data stable until the transfer.
//
// N <= 2**SEL_W is required so every input index fits in sel/out_src.
module mux_nway_reg #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SEL_W = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic [SEL_W-1:0]   sel,
    input  logic               mode,
    output logic [WIDTH-1:0]   out_data,
    output logic [SEL_W-1:0]   out_src,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               sel_err
);

    logic [SEL_W-1:0] rr_ptr;
    logic             grant_vld;
    logic [SEL_W-1:0] grant_idx;
    logic             sel_bad;
    logic             can_accept;
    logic             xfer;
    logic [WIDTH-1:0] grant_data;
    int               j;

    // Pick the granted input: explicit select, or first valid from rr_ptr upward with wrap.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        sel_bad   = 1'b0;
        j         = 0;
        if (!mode) begin
            if (int'(sel) < N) begin
                grant_vld = 1'b1;
                grant_idx = sel;
            end else begin
                sel_bad = 1'b1;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                j = int'(rr_ptr) + k;
                if (j >= N) j = j - N;
                if (!grant_vld && in_valid[j]) begin
                    grant_vld = 1'b1;
                    grant_idx = SEL_W'(j);
                end
            end
        end
    end

    // One-hot ready for the granted input; nothing is offered while in reset or full.
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < N; i++) begin
            in_ready[i] = grant_vld && (grant_idx == SEL_W'(i)) && can_accept && !rst;
        end
    end

    assign xfer       = |(in_valid & in_ready);
    assign grant_data = in_data[int'(grant_idx)*WIDTH +: WIDTH];

    // Round-robin pointer moves past the winner only on round-robin transfers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (xfer && mode) begin
            if (int'(grant_idx) == N - 1) rr_ptr <= '0;
            else                          rr_ptr <= grant_idx + SEL_W'(1);
        end
    end

    // Flag an out-of-range explicit select for one cycle whenever the stage could have accepted.
    always_ff @(posedge clk) begin
        if (rst) sel_err <= 1'b0;
        else     sel_err <= sel_bad && can_accept;
    end

`ifdef MUX_NWAY_SKID_EN

    logic             h_vld;
    logic             t_vld;
    logic [WIDTH-1:0] h_data;
    logic [WIDTH-1:0] t_data;
    logic [SEL_W-1:0] h_src;
    logic [SEL_W-1:0] t_src;
    logic             pop;

    // Ready comes purely from registered occupancy: room while fewer than two entries are held.
    assign can_accept = !(h_vld && t_vld);
    assign pop        = h_vld && out_ready;
    assign out_valid  = h_vld;
    assign out_data   = h_data;
    assign out_src    = h_src;

    // Two-entry in-order buffer: the head drives the outputs, the tail catches a word taken during a stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_vld  <= 1'b0;
            t_vld  <= 1'b0;
            h_data <= '0;
            t_data <= '0;
            h_src  <= '0;
            t_src  <= '0;
        end else begin
            case ({pop, xfer})
                2'b11: begin
                    if (t_vld) begin
                        h_data <= t_data;
                        h_src  <= t_src;
                        t_data <= grant_data;
                        t_src  <= grant_idx;
                    end else begin
                        h_data <= grant_data;
                        h_src  <= grant_idx;
                    end
                end
                2'b10: begin
                    if (t_vld) begin
                        h_data <= t_data;
                        h_src  <= t_src;
                    end
                    h_vld <= t_vld;
                    t_vld <= 1'b0;
                end
                2'b01: begin
                    if (!h_vld) begin
                        h_data <= grant_data;
                        h_src  <= grant_idx;
                        h_vld  <= 1'b1;
                    end else begin
                        t_data <= grant_data;
                        t_src  <= grant_idx;
                        t_vld  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`else

    logic             o_vld;
    logic [WIDTH-1:0] o_data;
    logic [SEL_W-1:0] o_src;

    // A held word blocks new input until the consumer takes it; take and refill may share a cycle.
    assign can_accept = !o_vld || out_ready;
    assign out_valid  = o_vld;
    assign out_data   = o_data;
    assign out_src    = o_src;

    // Single output register: load on transfer, drop valid once consumed, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_vld  <= 1'b0;
            o_data <= '0;
            o_src  <= '0;
        end else if (xfer) begin
            o_vld  <= 1'b1;
            o_data <= grant_data;
            o_src  <= grant_idx;
        end else if (out_ready) begin
            o_vld  <= 1'b0;
        end
    end

`endif

endmodule

// File: tb/tb_mux_nway_reg.sv
// Directed bench for mux_nway_reg: a driver issues vectors and pushes the
// hand-computed expected output words; a monitor pops and compares on each
// output handshake. A second instance with N=3 covers the illegal select.
module tb_mux_nway_reg;

  localparam int WIDTH = 32;
  localparam int N     = 4;
  localparam int SEL_W = 2;

  logic               clk;
  logic               rst;
  logic [WIDTH-1:0]   d [N];
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [SEL_W-1:0]   sel;
  logic               mode;
  logic [WIDTH-1:0]   out_data;
  logic [SEL_W-1:0]   out_src;
  logic               out_valid;
  logic               out_ready;
  logic               sel_err;

  logic [3*WIDTH-1:0] in_data3;
  logic [2:0]         in_valid3;
  logic [2:0]         in_ready3;
  logic [SEL_W-1:0]   sel3;
  logic [WIDTH-1:0]   out_data3;
  logic [SEL_W-1:0]   out_src3;
  logic               out_valid3;
  logic               sel_err3;

  logic [SEL_W+WIDTH-1:0] exp_q [$];
  int checks;
  int failures;

  assign in_data  = {d[3], d[2], d[1], d[0]};
  assign in_data3 = {32'h0000_0033, 32'h0000_0022, 32'h0000_0011};

  mux_nway_reg #(.WIDTH(WIDTH), .N(N), .SEL_W(SEL_W)) u_dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .sel(sel), .mode(mode), .out_data(out_data),
    .out_src(out_src), .out_valid(out_valid), .out_ready(out_ready),
    .sel_err(sel_err)
  );

  mux_nway_reg #(.WIDTH(WIDTH), .N(3), .SEL_W(SEL_W)) u_dut3 (
    .clk(clk), .rst(rst), .in_data(in_data3), .in_valid(in_valid3),
    .in_ready(in_ready3), .sel(sel3), .mode(1'b0), .out_data(out_data3),
    .out_src(out_src3), .out_valid(out_valid3), .out_ready(1'b1),
    .sel_err(sel_err3)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_word(input logic [SEL_W-1:0] src, input logic [WIDTH-1:0] data);
    exp_q.push_back({src, data});
  endtask

  // monitor: compare every output handshake against the expected queue
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", {out_src, out_data}, '0);
      end else begin
        logic [SEL_W+WIDTH-1:0] e;
        e = exp_q.pop_front();
        check("mon_out_data", out_data, e[WIDTH-1:0]);
        check("mon_out_src", out_src, e[SEL_W+WIDTH-1:WIDTH]);
      end
    end
  end

  // driver
  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    for (int i = 0; i < N; i++) d[i] = 32'hA000_0000 | 32'(i);
    in_valid = '1;
    sel = '0;
    mode = 1'b1;
    out_ready = 1'b1;
    in_valid3 = '0;
    sel3 = '0;

    // reset state
    tick();
    tick();
    check("rst_in_ready", in_ready, 4'b0000);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_out_src", out_src, 2'd0);
    check("rst_sel_err", sel_err, 1'b0);
    in_valid = '0;
    rst = 1'b0;
    tick();

    // explicit select
    mode = 1'b0;
    sel = 2'd2;
    d[2] = 32'hDEAD_BEEF;
    in_valid = 4'b0100;
    #1;
    check("expl_in_ready", in_ready, 4'b0100);
    expect_word(2'd2, 32'hDEAD_BEEF);
    tick();
    in_valid = '0;
    check("expl_out_valid", out_valid, 1'b1);
    check("expl_out_data", out_data, 32'hDEAD_BEEF);
    check("expl_sel_err", sel_err, 1'b0);
    tick();
    check("expl_drain_valid", out_valid, 1'b0);
    check("hold_out_data", out_data, 32'hDEAD_BEEF);

    // explicit select of a non-valid input: ready offered, nothing moves
    sel = 2'd1;
    in_valid = 4'b0100;
    #1;
    check("expl_idle_ready", in_ready, 4'b0010);
    tick();
    check("expl_idle_valid", out_valid, 1'b0);
    in_valid = '0;
    d[2] = 32'hA000_0002;

    // round-robin fairness, all inputs valid
    mode = 1'b1;
    in_valid = 4'b1111;
    for (int c = 0; c < 6; c++) begin
      logic [SEL_W-1:0] s;
      s = SEL_W'(c % N);
      #1;
      check("rr_in_ready", in_ready, 4'b0001 << s);
      expect_word(s, 32'hA000_0000 | 32'(s));
      tick();
      check("rr_no_bubble", out_valid, 1'b1);
    end
    in_valid = '0;
    tick();

    // sparse round-robin with wrap: pointer is 2, move it to 3, then only input 1
    in_valid = 4'b0100;
    #1;
    check("sparse_ready2", in_ready, 4'b0100);
    expect_word(2'd2, 32'hA000_0002);
    tick();
    in_valid = 4'b0010;
    #1;
    check("sparse_wrap_ready", in_ready, 4'b0010);
    expect_word(2'd1, 32'hA000_0001);
    tick();
    in_valid = 4'b1111;
    #1;
    check("sparse_ptr_after", in_ready, 4'b0100);
    expect_word(2'd2, 32'hA000_0002);
    tick();
    in_valid = '0;
    tick();

    // backpressure
    mode = 1'b0;
    sel = 2'd0;
    d[0] = 32'h1234_5678;
    in_valid = 4'b0001;
    expect_word(2'd0, 32'h1234_5678);
    tick();
    out_ready = 1'b0;
    sel = 2'd1;
    d[1] = 32'hCAFE_F00D;
    in_valid = 4'b0010;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("stall_in_ready", in_ready, 4'b0000);
      check("stall_out_valid", out_valid, 1'b1);
      check("stall_out_data", out_data, 32'h1234_5678);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("refill_in_ready", in_ready, 4'b0010);
    expect_word(2'd1, 32'hCAFE_F00D);
    tick();
    in_valid = '0;
    check("refill_out_valid", out_valid, 1'b1);
    check("refill_out_data", out_data, 32'hCAFE_F00D);
    tick();
    check("refill_drain", out_valid, 1'b0);

    // reset mid-stall: the held word is dropped, round-robin restarts at 0
    sel = 2'd3;
    d[3] = 32'h55AA_55AA;
    in_valid = 4'b1000;
    tick();
    in_valid = '0;
    out_ready = 1'b0;
    tick();
    check("pre_rst_valid", out_valid, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("post_rst_valid", out_valid, 1'b0);
    d[0] = 32'hA000_0000;
    out_ready = 1'b1;
    mode = 1'b1;
    in_valid = 4'b1111;
    #1;
    check("post_rst_rr_first", in_ready, 4'b0001);
    expect_word(2'd0, 32'hA000_0000);
    tick();
    in_valid = '0;
    tick();

    // illegal select on the N=3 instance
    sel3 = 2'd3;
    in_valid3 = 3'b111;
    #1;
    check("illegal_in_ready", in_ready3, 3'b000);
    tick();
    sel3 = 2'd0;
    in_valid3 = 3'b000;
    check("illegal_sel_err", sel_err3, 1'b1);
    check("illegal_no_xfer", out_valid3, 1'b0);
    tick();
    check("illegal_err_pulse", sel_err3, 1'b0);

    // drain scoreboard with a bounded wait
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) tick();
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
